branch_target_table: RTL and testbench
======================================

// Module: branch_target_table
// PURPOSE
//  Programmable successor to the fixed branch-target lookup: maps a short branch-pointer field to a
//  full-width PC target. Sits between decode (pointer field) and fetch (PC mux).
//  Resets to a built-in default target image, loaded one entry per cycle by an init sequencer.
//  Runtime rewritable via a write port; read port is registered, 1-cycle latency.
// PARAMETERS
//  AW     4            pointer (index) width; DEPTH = 2**AW entries
//  DW     8            target width; default image zero-extended when DW > 8
// PORTS
//  Clk        in   1    system clock, rising edge
//  Reset      in   1    asynchronous, active-high reset
//  rd_en      in   1    lookup request this cycle
//  rd_addr    in   AW   branch pointer
//  Target     out  DW   looked-up target, valid when rd_valid
//  rd_valid   out  1    Target holds result of rd_en from previous cycle
//  wr_en      in   1    write request (accepted only when wr_ready)
//  wr_addr    in   AW   entry to rewrite
//  wr_data    in   DW   new target
//  wr_ready   out  1    0 during init; writes with wr_ready=0 are dropped
//  init_busy  out  1    1 while default image is being loaded
// BEHAVIOUR
//  Reset values: Target=0, rd_valid=0, wr_ready=0, init_busy=1, init pointer=0, state=INIT.
//  Storage is flops, not cleared by Reset; content is undefined until INIT completes.
//  FSM INIT: each cycle write default[ptr] to entry ptr, ptr++; at ptr==DEPTH-1, write it, go READY.
//   INIT takes exactly DEPTH cycles after Reset deasserts; init_busy/wr_ready flip on the same edge.
//  FSM READY: terminal; only Reset returns to INIT. Reset mid-INIT restarts at ptr=0.
//  Default image (index:value): 0:0 1:1 2:30 3:31 4:64 5:65 6:94 7:95 8:128 9:129 10:160 11:192
//   12:193 13:194; all other indices 0. Indices >= DEPTH are not loaded when AW < 4.
//  Read: rd_en at edge N -> Target/rd_valid updated at edge N+1; rd_en=0 -> rd_valid=0, Target holds.
//   rd_en during INIT -> rd_valid=0 next cycle (request dropped, no stall).
//  Write: wr_en && wr_ready at edge N updates entry at edge N.
//  Same-cycle wr/rd to same address: read returns wr_data (write-first bypass).
//  Same-cycle wr/rd to different addresses: independent.
//  All arithmetic unsigned; ptr is AW bits, no wrap (FSM leaves INIT before overflow).
// CONFIGURATION
//  BTT_PARITY_EN defined: each entry stores an extra even-parity bit computed on write/init;
//   extra output parity_err (1 bit, reset 0) asserted with rd_valid when stored parity mismatches data.
//   Target still driven with stored data.
//  BTT_PARITY_EN undefined: no parity storage, no parity_err port.
// STRUCTURE
//  Package btt_pkg: state enum {INIT, READY}; function default_target(idx) returning 8-bit image value;
//   localparam DEF_W = 8.
//  Sub-module btt_init_seq: INIT/READY FSM and pointer; outputs init_we, init_addr, init_busy.
//   Storage, read register, bypass and parity remain in the top module.
// TESTING
//  Reset pulse, hold rd_en=1 addr=2 -> rd_valid=0 for 16 cycles, then Target=30 rd_valid=1; init_busy low after 16.
//  After init, read all 16 addresses back-to-back -> image values in order, one per cycle, 1-cycle latency.
//  wr_en addr=5 data=8'hA7 with rd_en addr=5 same cycle -> next cycle Target=8'hA7; later read also 8'hA7.
//  wr_en addr=3 data=8'h11 during INIT -> dropped; read 3 after init returns 31.
//  Assert Reset at init cycle 7 after first entries -> init_busy stays 1, full 16-cycle reload, entry 0 reads 0.
//  BTT_PARITY_EN: force-flip one stored data bit of entry 9 -> read 9 gives parity_err=1, Target=129^bit.

Source files
------------

// File: rtl/btt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btt_pkg
//  Description : Shared types and the built-in default target image for the
//                branch target table.
//  Revision    : 1.0 - initial release
// ============================================================================
package btt_pkg;

    // Width of the built-in default image values
    localparam int DEF_W = 8;

    // Init sequencer states
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } btt_state_t;

    // Built-in default target image; indices not listed map to zero
    function automatic logic [DEF_W-1:0] default_target(input int unsigned idx);
        case (idx)
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd30;
            3:       return 8'd31;
            4:       return 8'd64;
            5:       return 8'd65;
            6:       return 8'd94;
            7:       return 8'd95;
            8:       return 8'd128;
            9:       return 8'd129;
            10:      return 8'd160;
            11:      return 8'd192;
            12:      return 8'd193;
            13:      return 8'd194;
            default: return 8'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/btt_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : btt_init_seq
//  Description : Init sequencer for the branch target table. After reset it
//                walks every entry once (one per cycle) requesting a default
//                image write, then parks in READY until the next reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module btt_init_seq
    import btt_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          init_busy
);

    localparam logic [AW-1:0] c_last_ptr = {AW{1'b1}};

    btt_state_t    r_state;
    btt_state_t    w_state_next;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_next;

    // State and pointer registers; reset (also mid-init) restarts the walk at entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state logic: one entry per cycle; the last entry is written on the READY transition
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        init_we      = 1'b0;
        init_busy    = 1'b0;
        case (r_state)
            INIT: begin
                init_we   = 1'b1;
                init_busy = 1'b1;
                if (r_ptr == c_last_ptr) begin
                    w_state_next = READY;
                end else begin
                    w_ptr_next = r_ptr + AW'(1);
                end
            end
            READY: begin
                w_state_next = READY;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    assign init_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/branch_target_table.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_table
//  Description : Programmable branch-pointer to PC-target lookup. Loads a
//                built-in default image after reset, accepts runtime writes
//                once ready, and returns lookups with one cycle of latency
//                and a write-first bypass for same-address read/write.
//                Optional macro BTT_PARITY_EN adds per-entry even parity and
//                a parity_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_table
    import btt_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] Target,
    output logic          rd_valid,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          init_busy
`ifdef BTT_PARITY_EN
    ,
    output logic          parity_err
`endif
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic          w_init_we;
    logic [AW-1:0] w_init_addr;
    logic [DW-1:0] w_init_value;
    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_bypass;
    logic [DW-1:0] w_rd_data;

    btt_init_seq #(
        .AW(AW)
    ) u_init_seq (
        .clk       (Clk),
        .rst       (Reset),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .init_busy (init_busy)
    );

    // Default image is zero-extended (or truncated) to the stored target width
    assign w_init_value = DW'(default_target(32'(w_init_addr)));

    assign wr_ready  = ~init_busy;
    assign w_wr_fire = wr_en & wr_ready;
    assign w_rd_fire = rd_en & ~init_busy;
    assign w_bypass  = w_wr_fire && (wr_addr == rd_addr);
    assign w_rd_data = w_bypass ? wr_data : r_mem[rd_addr];

    // Entry storage: init image writes own the array while busy, otherwise the write port
    always_ff @(posedge Clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= w_init_value;
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; reads during init are dropped and Target holds when idle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Target   <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                Target <= w_rd_data;
            end
        end
    end

`ifdef BTT_PARITY_EN
    logic r_par [DEPTH];
    logic w_rd_par;

    assign w_rd_par = w_bypass ? (^wr_data) : r_par[rd_addr];

    // Parity storage mirrors the data array; even parity means bit = XOR of data
    always_ff @(posedge Clk) begin
        if (w_init_we) begin
            r_par[w_init_addr] <= ^w_init_value;
        end else if (w_wr_fire) begin
            r_par[wr_addr] <= ^wr_data;
        end
    end

    // Parity check flag accompanies each accepted read
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_rd_fire && (w_rd_par != (^w_rd_data));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_table
//  Description : Directed self-checking bench for branch_target_table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_table;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] Target;
    logic       rd_valid;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       init_busy;
`ifdef BTT_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int img [16] = '{0, 1, 30, 31, 64, 65, 94, 95, 128, 129, 160, 192, 193, 194, 0, 0};

    branch_target_table #(
        .AW(4),
        .DW(8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .Target    (Target),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .init_busy (init_busy)
`ifdef BTT_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge and settle just after it
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Reset pulse, then wait (bounded) for init to finish
    task automatic reset_and_init();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 40 && init_busy; i++) cyc();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        rd_en = 1'b1;
        rd_addr = 4'd2;
        cyc();
        checks++;
        if (Target !== 8'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got Target=%0d rd_valid=%b wr_ready=%b init_busy=%b, want 0 0 0 1",
                     Target, rd_valid, wr_ready, init_busy);
        end
        Reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL init_read_dropped edge %0d: got rd_valid=%b want 0", k, rd_valid);
            end
            checks++;
            if (init_busy !== (k < 16)) begin
                errors++;
                $display("FAIL init_busy edge %0d: got %b want %b", k, init_busy, (k < 16));
            end
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_after_init: got %b want 1", wr_ready);
        end
        cyc();
        checks++;
        if (rd_valid !== 1'b1 || Target !== 8'd30) begin
            errors++;
            $display("FAIL first_read: got rd_valid=%b Target=%0d want 1 30", rd_valid, Target);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_read_all();
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            cyc();
            checks++;
            if (rd_valid !== 1'b1 || Target !== 8'(img[i])) begin
                errors++;
                $display("FAIL read_all[%0d]: got rd_valid=%b Target=%0d want 1 %0d", i, rd_valid, Target, img[i]);
            end
        end
        rd_addr = 4'd13;
        cyc();
        rd_en = 1'b0;
        rd_addr = 4'd1;
        cyc();
        checks++;
        if (rd_valid !== 1'b0 || Target !== 8'd194) begin
            errors++;
            $display("FAIL idle_hold: got rd_valid=%b Target=%0d want 0 194", rd_valid, Target);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hA7;
        rd_en = 1'b1; rd_addr = 4'd5;
        cyc();
        checks++;
        if (rd_valid !== 1'b1 || Target !== 8'hA7) begin
            errors++;
            $display("FAIL bypass_same_addr: got rd_valid=%b Target=%h want 1 a7", rd_valid, Target);
        end
        wr_en = 1'b0;
        cyc();
        checks++;
        if (Target !== 8'hA7) begin
            errors++;
            $display("FAIL bypass_readback: got Target=%h want a7", Target);
        end
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h5C;
        rd_addr = 4'd7;
        cyc();
        checks++;
        if (Target !== 8'd95) begin
            errors++;
            $display("FAIL diff_addr_read: got Target=%0d want 95", Target);
        end
        wr_en = 1'b0;
        rd_addr = 4'd6;
        cyc();
        checks++;
        if (Target !== 8'h5C) begin
            errors++;
            $display("FAIL diff_addr_write: got Target=%h want 5c", Target);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_init_write_drop();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_during_init: got %b want 0", wr_ready);
        end
        for (int i = 0; i < 40 && init_busy; i++) cyc();
        wr_en = 1'b0;
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_timeout: got init_busy=%b want 0", init_busy);
        end
        rd_en = 1'b1; rd_addr = 4'd3;
        cyc();
        rd_en = 1'b0;
        checks++;
        if (Target !== 8'd31) begin
            errors++;
            $display("FAIL init_write_dropped: got Target=%0d want 31", Target);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hEE;
        cyc();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 4'd0;
        cyc();
        rd_en = 1'b0;
        checks++;
        if (Target !== 8'hEE) begin
            errors++;
            $display("FAIL pre_reset_write: got Target=%h want ee", Target);
        end
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        Reset = 1'b1;
        #1;
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_init_busy: got %b want 1", init_busy);
        end
        cyc();
        Reset = 1'b0;
        n = 0;
        while (init_busy && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL reload_length: got %0d cycles want 16", n);
        end
        rd_en = 1'b1; rd_addr = 4'd0;
        cyc();
        checks++;
        if (Target !== 8'd0) begin
            errors++;
            $display("FAIL reload_entry0: got Target=%0d want 0", Target);
        end
        rd_addr = 4'd5;
        cyc();
        rd_en = 1'b0;
        checks++;
        if (Target !== 8'd65) begin
            errors++;
            $display("FAIL reload_entry5: got Target=%0d want 65", Target);
        end
    endtask

`ifdef BTT_PARITY_EN
    task automatic test_parity();
        dut.r_mem[9] = dut.r_mem[9] ^ 8'h04;
        rd_en = 1'b1; rd_addr = 4'd9;
        cyc();
        checks++;
        if (parity_err !== 1'b1 || Target !== 8'd133) begin
            errors++;
            $display("FAIL parity_flip: got parity_err=%b Target=%0d want 1 133", parity_err, Target);
        end
        rd_addr = 4'd8;
        cyc();
        rd_en = 1'b0;
        checks++;
        if (parity_err !== 1'b0 || Target !== 8'd128) begin
            errors++;
            $display("FAIL parity_clean: got parity_err=%b Target=%0d want 0 128", parity_err, Target);
        end
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_read_all();
        test_bypass();
        test_init_write_drop();
        test_reset_mid_init();
`ifdef BTT_PARITY_EN
        reset_and_init();
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
